// File: rtl/rollover_pkg.sv
// Shared types and constants for the rollover counter slice.
package rollover_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_e;

  localparam int unsigned DEFAULT_PERIOD = 9;

endpackage

// File: rtl/period_slot.sv
// One-entry valid/ready holding register for a requested period; the apply
// strobe empties it so the owner can consume the held value.
module period_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_apply,
  output logic             o_pend_valid,
  output logic [WIDTH-1:0] o_pend_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Loads are only accepted while empty, so apply and load never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q && i_apply) begin
      full_d = 1'b0;
    end else if (!full_q && i_valid) begin
      full_d = 1'b1;
      data_d = i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign o_ready      = ~full_q;
  assign o_pend_valid = full_q;
  assign o_pend_data  = data_q;

endmodule

// File: rtl/rollover_counter.sv
// Programmable-period counter with a registered wrap pulse; new periods are
// staged in a one-entry slot and take effect at the wrap or while idle.
module rollover_counter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEFAULT_PERIOD = rollover_pkg::DEFAULT_PERIOD
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_period,
  input  logic             i_period_valid,
  output logic             o_period_ready,
  output logic [WIDTH-1:0] o_count,
  output logic             o_roll_over
);

  import rollover_pkg::*;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] active_q;
  logic             roll_q;

  logic             pend_valid;
  logic [WIDTH-1:0] pend_data;
  logic [WIDTH-1:0] eff_period;
  logic             wrap;
  logic             apply;

  period_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_valid      (i_period_valid),
    .i_data       (i_period),
    .o_ready      (o_period_ready),
    .i_apply      (apply),
    .o_pend_valid (pend_valid),
    .o_pend_data  (pend_data)
  );

  // Idle always sits at count 0, so a period applied there is compared
  // against on the same edge; otherwise it only lands at the wrap.
  always_comb begin
    eff_period = active_q;
    if (state_q == IDLE && pend_valid) begin
      eff_period = pend_data;
    end
    wrap  = i_enable && (count_q == eff_period);
    apply = (state_q == IDLE) || wrap;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      active_q <= WIDTH'(DEFAULT_PERIOD);
      roll_q   <= 1'b0;
    end else begin
      roll_q <= wrap;
      if (apply && pend_valid) begin
        active_q <= pend_data;
      end
      if (i_enable) begin
        count_q <= wrap ? '0 : count_q + 1'b1;
      end
      case (state_q)
        IDLE:    if (i_enable) state_q <= RUN;
        RUN:     if (!i_enable) state_q <= (count_q == '0) ? IDLE : HOLD;
        HOLD:    if (i_enable) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_count     = count_q;
  assign o_roll_over = roll_q;

endmodule
